// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the chord voice scheduler: default sizes, index widths
// and the scheduler FSM state encoding.
package voice_scheduler_pkg;

  localparam int DEF_NUM_VOICES = 3;
  localparam int DEF_PHASE_W    = 22;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_SAMPLE_W   = 16;

  // Voice index port width is fixed so up to 8 voices can be addressed.
  localparam int VOICE_IDX_W = 3;
  localparam int CUR_W       = VOICE_IDX_W + 1;
  localparam int HEADROOM_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/voice_phase_bank.sv
// Per-voice step/phase register file: load port (sets step, clears phase),
// advance port (phase += step for one voice) and lookup-address/active read ports.
module voice_phase_bank
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_valid_i,
  input  logic [VOICE_IDX_W-1:0] load_voice_i,
  input  logic [PHASE_W-1:0]     load_step_i,
  input  logic                   adv_en_i,
  input  logic [VOICE_IDX_W-1:0] adv_idx_i,
  input  logic [VOICE_IDX_W-1:0] rd_idx_i,
  output logic [ADDR_W-1:0]      rd_addr_o,
  output logic [NUM_VOICES-1:0]  active_o
);

  logic [PHASE_W-1:0] step_q  [NUM_VOICES];
  logic [PHASE_W-1:0] step_d  [NUM_VOICES];
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];

  // A load beats an advance on the same voice: the new step starts from phase 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    step_d  = step_q;
    phase_d = phase_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (load_valid_i && load_voice_i == VOICE_IDX_W'(v)) begin
        step_d[v]  = load_step_i;
        phase_d[v] = '0;
      end else if (adv_en_i && adv_idx_i == VOICE_IDX_W'(v)) begin
        phase_d[v] = phase_q[v] + step_q[v];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this small register file is reset because silent voices must start at step 0.
      for (int v = 0; v < NUM_VOICES; v++) begin
        step_q[v]  <= '0;
        phase_q[v] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      step_q  <= step_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    rd_addr_o = '0;
    active_o  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      active_o[v] = |step_q[v];
      if (rd_idx_i == VOICE_IDX_W'(v)) begin
        rd_addr_o = phase_q[v][PHASE_W-1 -: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Shares one phase->sample lookup across the chord voices: once per codec frame it
// fetches every enabled voice in index order, advances its phase and mixes the samples.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SAMPLE_W   = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                play,
  input  logic                new_frame,
  input  logic                load_valid,
  input  logic [2:0]          load_voice,
  input  logic [PHASE_W-1:0]  load_step,
  output logic                lut_req,
  output logic [ADDR_W-1:0]   lut_addr,
  input  logic                lut_ack,
  input  logic                lut_rvalid,
  input  logic [SAMPLE_W-1:0] lut_rdata,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                overrun
);

  localparam int ACC_W = SAMPLE_W + HEADROOM_W;

  sched_state_e           state_q;
  logic [CUR_W-1:0]       cur_q;
  logic [VOICE_IDX_W-1:0] sel_q;
  logic [ACC_W-1:0]       acc_q;
  logic                   lut_req_q;
  logic [ADDR_W-1:0]      lut_addr_q;
  logic [SAMPLE_W-1:0]    sample_out_q;
  logic                   sample_valid_q;
  logic                   overrun_q;

  logic                   found;
  logic [VOICE_IDX_W-1:0] next_idx;
  logic [ADDR_W-1:0]      next_addr;
  logic [NUM_VOICES-1:0]  active;
  logic                   adv_en;

  assign adv_en = (state_q == ST_WAIT) && lut_rvalid;

  voice_phase_bank #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W),
    .ADDR_W     (ADDR_W)
  ) u_bank (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_valid_i (load_valid),
    .load_voice_i (load_voice),
    .load_step_i  (load_step),
    .adv_en_i     (adv_en),
    .adv_idx_i    (sel_q),
    .rd_idx_i     (next_idx),
    .rd_addr_o    (next_addr),
    .active_o     (active)
  );

  // Lowest-numbered enabled voice at or above the scan cursor.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (active[v] && CUR_W'(v) >= cur_q) begin
        found    = 1'b1;
        next_idx = VOICE_IDX_W'(v);
      end
    end
  end

  // The accumulator is in range only while all headroom bits match the sample sign bit.
  function automatic logic [SAMPLE_W-1:0] saturate(input logic [ACC_W-1:0] a);
    logic [HEADROOM_W:0] top;
    top = a[ACC_W-1 -: HEADROOM_W+1];
    if (top == '0 || top == '1) begin
      return a[SAMPLE_W-1:0];
    end else if (a[ACC_W-1]) begin
      return {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cur_q          <= '0;
      sel_q          <= '0;
      acc_q          <= '0;
      lut_req_q      <= 1'b0;
      lut_addr_q     <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if (new_frame && state_q != ST_IDLE) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (new_frame) begin
            if (play) begin
              state_q <= ST_SCAN;
            end else begin
              sample_out_q   <= '0;
              sample_valid_q <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          // Address is captured here so a load during the fetch cannot disturb it.
          if (found) begin
            sel_q      <= next_idx;
            lut_addr_q <= next_addr;
            lut_req_q  <= 1'b1;
            state_q    <= ST_ISSUE;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_ISSUE: begin
          if (lut_ack) begin
            lut_req_q <= 1'b0;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lut_rvalid) begin
            acc_q   <= acc_q + {{HEADROOM_W{lut_rdata[SAMPLE_W-1]}}, lut_rdata};
            cur_q   <= CUR_W'(sel_q) + CUR_W'(1);
            state_q <= ST_SCAN;
          end
        end
        ST_DONE: begin
          sample_out_q   <= saturate(acc_q);
          sample_valid_q <= 1'b1;
          acc_q          <= '0;
          cur_q          <= '0;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lut_req      = lut_req_q;
  assign lut_addr     = lut_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: a frame-level model predicts lookup addresses
// and mixed samples; a responder emulates the shared lookup with variable ack/latency.
`timescale 1ns/1ps
module tb_voice_scheduler;

  localparam int NV = 3;
  localparam int PW = 22;
  localparam int AW = 10;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          play = 1'b0;
  logic          new_frame = 1'b0;
  logic          load_valid = 1'b0;
  logic [2:0]    load_voice = '0;
  logic [PW-1:0] load_step = '0;
  logic          lut_req;
  logic [AW-1:0] lut_addr;
  logic          lut_ack = 1'b0;
  logic          lut_rvalid = 1'b0;
  logic [SW-1:0] lut_rdata = '0;
  logic [SW-1:0] sample_out;
  logic          sample_valid;
  logic          overrun;

  voice_scheduler #(
    .NUM_VOICES (NV),
    .PHASE_W    (PW),
    .ADDR_W     (AW),
    .SAMPLE_W   (SW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .play         (play),
    .new_frame    (new_frame),
    .load_valid   (load_valid),
    .load_voice   (load_voice),
    .load_step    (load_step),
    .lut_req      (lut_req),
    .lut_addr     (lut_addr),
    .lut_ack      (lut_ack),
    .lut_rvalid   (lut_rvalid),
    .lut_rdata    (lut_rdata),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Lookup contents: a fixed value for directed tests, otherwise a hash of the address.
  bit            fixed_en = 1'b0;
  logic [SW-1:0] fixed_val = '0;
  int            fix_lat = 0;
  int            force_stall = -1;

  function automatic logic [SW-1:0] lut_data(input logic [AW-1:0] a);
    logic [SW-1:0] h;
    h = {6'b0, a} * 16'd40503;
    h = h ^ {a[5:0], a} ^ 16'h5A3C;
    return fixed_en ? fixed_val : h;
  endfunction

  // Frame-level reference model.
  logic [PW-1:0] m_step  [NV];
  logic [PW-1:0] m_phase [NV];
  logic [AW-1:0] exp_addrs[$];
  logic [SW-1:0] exp_samples[$];

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_step[v]  = '0;
      m_phase[v] = '0;
    end
    exp_addrs.delete();
    exp_samples.delete();
  endtask

  task automatic model_load(input int v, input logic [PW-1:0] s);
    if (v < NV) begin
      m_step[v]  = s;
      m_phase[v] = '0;
    end
  endtask

  task automatic model_frame(input bit pl);
    int sum;
    logic [AW-1:0] a;
    sum = 0;
    if (pl) begin
      for (int v = 0; v < NV; v++) begin
        if (m_step[v] != 0) begin
          a = AW'(m_phase[v] >> (PW - AW));
          exp_addrs.push_back(a);
          sum += int'($signed(lut_data(a)));
          m_phase[v] = m_phase[v] + m_step[v];
        end
      end
    end
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
    exp_samples.push_back(SW'(sum));
  endtask

  // Observations gathered by the compare process.
  int            cyc = 0;
  int            n_valid = 0;
  int            n_hs = 0;
  int            valid_cyc = 0;
  int            req_run = 0;
  int            last_req_run = 0;
  logic [SW-1:0] last_sample = '0;
  logic [AW-1:0] hs_log[$];
  bit            prev_wait_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_n) begin
      req_run       = 0;
      prev_wait_ack = 1'b0;
    end else begin
      if (prev_wait_ack) check("req_held", 32'(lut_req), 32'd1);
      if (lut_req) req_run++;
      else req_run = 0;
      if (lut_req && lut_ack) begin
        n_hs++;
        hs_log.push_back(lut_addr);
        last_req_run = req_run;
        check("hs_expected", 32'(exp_addrs.size() != 0), 32'd1);
        if (exp_addrs.size() != 0) check("lut_addr", 32'(lut_addr), 32'(exp_addrs.pop_front()));
      end
      if (sample_valid) begin
        n_valid++;
        valid_cyc   = cyc;
        last_sample = sample_out;
        check("valid_expected", 32'(exp_samples.size() != 0), 32'd1);
        if (exp_samples.size() != 0) check("sample_out", 32'(sample_out), 32'(exp_samples.pop_front()));
      end
      prev_wait_ack = lut_req && !lut_ack;
    end
  end

  // Shared lookup emulation: optional ack stall, then rdata fix_lat (or random) cycles after ack.
  initial begin : responder
    logic [AW-1:0] r_addr;
    int r_wait;
    int stall_cnt;
    bit in_req;
    r_addr = '0;
    r_wait = 0;
    stall_cnt = 0;
    in_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      lut_ack    = 1'b0;
      lut_rvalid = 1'b0;
      if (r_wait > 0) begin
        r_wait--;
        if (r_wait == 0) begin
          lut_rvalid = 1'b1;
          lut_rdata  = lut_data(r_addr);
        end
      end
      if (!reset_n) begin
        in_req = 1'b0;
      end else begin
        if (!in_req && lut_req && r_wait == 0) begin
          in_req    = 1'b1;
          stall_cnt = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 2));
        end
        if (in_req) begin
          if (stall_cnt > 0) begin
            stall_cnt--;
          end else begin
            lut_ack = 1'b1;
            in_req  = 1'b0;
            r_addr  = lut_addr;
            r_wait  = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 4));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int start_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v, input logic [PW-1:0] s);
    load_valid = 1'b1;
    load_voice = 3'(v);
    load_step  = s;
    model_load(v, s);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wait_valid(input int prev, input int budget);
    int t;
    t = 0;
    while (n_valid == prev && t < budget) begin
      tick();
      t++;
    end
    check("frame_done", 32'(n_valid != prev), 32'd1);
  endtask

  task automatic frame(input bit pl);
    int prev;
    prev = n_valid;
    play = pl;
    model_frame(pl);
    new_frame = 1'b1;
    start_cyc = cyc;
    tick();
    new_frame = 1'b0;
    wait_valid(prev, 300);
  endtask

  initial begin : main
    int prev;
    int prev_hs;
    int t;
    int v;
    logic [PW-1:0] s;

    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_lut_req", 32'(lut_req), 32'd0);
    check("rst_lut_addr", 32'(lut_addr), 32'd0);
    check("rst_sample_out", 32'(sample_out), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Single voice, constant lookup value, latency 2.
    fixed_en = 1'b1;
    fixed_val = 16'h1234;
    fix_lat = 2;
    force_stall = 0;
    do_load(0, 22'h001000);
    hs_log.delete();
    frame(1'b1);
    check("t1_hs_count", 32'(hs_log.size()), 32'd1);
    if (hs_log.size() >= 1) check("t1_addr0", 32'(hs_log[0]), 32'h000);
    check("t1_sample", 32'(last_sample), 32'h1234);
    check("t1_latency_bound", 32'((valid_cyc - start_cyc - 1) <= 9), 32'd1);
    frame(1'b1);
    check("t1_hs_count2", 32'(hs_log.size()), 32'd2);
    if (hs_log.size() >= 2) check("t1_addr1", 32'(hs_log[1]), 32'h001);
    force_stall = -1;
    fix_lat = 0;

    // No active voice: zero output two cycles after the frame starts.
    do_load(0, '0);
    frame(1'b1);
    check("zero_voice_latency", 32'(valid_cyc - start_cyc - 1), 32'd2);
    check("zero_voice_sample", 32'(last_sample), 32'h0000);

    // Saturation in both directions.
    do_load(0, 22'h000100);
    do_load(1, 22'h000200);
    do_load(2, 22'h000300);
    fixed_val = 16'h7000;
    frame(1'b1);
    check("sat_pos", 32'(last_sample), 32'h7FFF);
    fixed_val = 16'h9000;
    frame(1'b1);
    check("sat_neg", 32'(last_sample), 32'h8000);
    fixed_en = 1'b0;

    // Voices 0 and 2 active, voice 1 disabled.
    do_load(0, 22'h001000);
    do_load(1, '0);
    do_load(2, 22'h005000);
    frame(1'b1);
    hs_log.delete();
    frame(1'b1);
    check("skip_hs_count", 32'(hs_log.size()), 32'd2);
    if (hs_log.size() >= 2) begin
      check("skip_addr_v0", 32'(hs_log[0]), 32'h001);
      check("skip_addr_v2", 32'(hs_log[1]), 32'h005);
    end

    // Phase wrap with maximum step; ack stalled for 5 cycles on the second frame.
    do_load(0, 22'h3FFFFF);
    do_load(2, '0);
    hs_log.delete();
    frame(1'b1);
    force_stall = 5;
    frame(1'b1);
    check("stall_req_cycles", 32'(last_req_run), 32'd6);
    force_stall = -1;
    frame(1'b1);
    check("wrap_hs_count", 32'(hs_log.size()), 32'd3);
    if (hs_log.size() >= 3) begin
      check("wrap_addr_f1", 32'(hs_log[0]), 32'h000);
      check("wrap_addr_f2", 32'(hs_log[1]), 32'h3FF);
      check("wrap_addr_f3", 32'(hs_log[2]), 32'h3FF);
    end
    check("wrap_no_overrun", 32'(overrun), 32'd0);

    // Second new_frame while waiting on the lookup.
    do_load(0, 22'h001000);
    fix_lat = 3;
    prev = n_valid;
    prev_hs = n_hs;
    play = 1'b1;
    model_frame(1'b1);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    t = 0;
    while (n_hs == prev_hs && t < 50) begin
      tick();
      t++;
    end
    check("ovr_hs_seen", 32'(n_hs != prev_hs), 32'd1);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    wait_valid(prev, 300);
    repeat (20) tick();
    check("ovr_single_valid", 32'(n_valid - prev), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    fix_lat = 0;

    // Paused frame outputs zero and holds phases; same-cycle load and frame.
    frame(1'b0);
    check("pause_sample", 32'(last_sample), 32'h0000);
    frame(1'b1);
    prev = n_valid;
    play = 1'b1;
    load_valid = 1'b1;
    load_voice = 3'd1;
    load_step = 22'h012345;
    model_load(1, 22'h012345);
    model_frame(1'b1);
    new_frame = 1'b1;
    start_cyc = cyc;
    tick();
    new_frame = 1'b0;
    load_valid = 1'b0;
    wait_valid(prev, 300);

    // Randomized loads between frames, random play, random ack stalls and latency.
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        v = int'($urandom_range(0, 7));
        s = ($urandom_range(0, 3) == 0) ? '0 : PW'($urandom);
        do_load(v, s);
      end
      frame($urandom_range(0, 4) != 0);
      play = $urandom_range(0, 1) == 1;
    end
    check("sticky_overrun", 32'(overrun), 32'd1);

    // Reset while a lookup is outstanding; its late rvalid must be ignored.
    do_load(0, 22'h002000);
    fix_lat = 6;
    prev = n_valid;
    prev_hs = n_hs;
    play = 1'b1;
    model_frame(1'b1);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    t = 0;
    while (n_hs == prev_hs && t < 50) begin
      tick();
      t++;
    end
    check("rst_hs_seen", 32'(n_hs != prev_hs), 32'd1);
    reset_n = 1'b0;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("rst2_lut_req", 32'(lut_req), 32'd0);
    check("rst2_sample_out", 32'(sample_out), 32'd0);
    check("rst2_overrun", 32'(overrun), 32'd0);
    repeat (8) tick();
    check("rst2_no_valid", 32'(n_valid - prev), 32'd0);
    fix_lat = 0;
    frame(1'b1);
    check("rst2_acc_clear", 32'(last_sample), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
